// File: rtl/alu_md_pkg.sv
// Shared types, constants and the flag encoder for the multiply/divide unit.
package alu_md_pkg;

    localparam int W = 16;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Flag vector for a finished operation; hi/lo are the final result words.
    function automatic logic [3:0] calc_flags(input logic op, input logic dz,
                                              input logic [W-1:0] hi,
                                              input logic [W-1:0] lo);
        logic [3:0] f;
        f = '0;
        if (op == OP_MUL) begin
            f[FLG_Z] = ({hi, lo} == '0);
            f[FLG_N] = hi[W-1];
            f[FLG_C] = (hi != '0);
        end else begin
            f[FLG_Z] = (lo == '0);
            f[FLG_N] = lo[W-1];
            f[FLG_V] = dz;
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_md_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface alu_md_if;
    import alu_md_pkg::*;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] res_lo;
    logic [W-1:0] res_hi;
    logic [3:0]   flags_out;
    logic         flags_en;

    modport master (output start, op, a, b,
                    input  busy, done, res_lo, res_hi, flags_out, flags_en);
    modport slave  (input  start, op, a, b,
                    output busy, done, res_lo, res_hi, flags_out, flags_en);
endinterface

// File: rtl/md_iter_datapath.sv
// One-bit-per-cycle shift-add multiplier / restoring divider datapath.
// hi holds the upper accumulator (MUL) or the remainder (DIV); lo holds the
// multiplier (MUL) or the quotient (DIV) and shares the shift with hi.
module md_iter_datapath
    import alu_md_pkg::*;
(
    input  logic         clk,
    input  logic         rst_b,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         op_i,
    input  logic         dz_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         op_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o,
    output logic [W-1:0] hi_d_o,
    output logic [W-1:0] lo_d_o
);

    logic [W-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic         op_q, op_d;
    logic [W:0]   sum;
    logic [W:0]   rem_s;
    logic         ge;
    logic [W-1:0] diff;

    // Next-value logic: operand load, or one multiply/divide iteration.
    always_comb begin
        sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
        rem_s = {hi_q, lo_q[W-1]};
        ge    = (rem_s >= {1'b0, opnd_q});
        // When ge holds the difference is below the divisor, so W bits suffice.
        diff  = rem_s[W-1:0] - opnd_q;

        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        op_d   = op_q;

        if (load_i) begin
            op_d = op_i;
            if (dz_i) begin
                hi_d   = a_i;
                lo_d   = '1;
                opnd_d = '0;
            end else if (op_i == OP_MUL) begin
                hi_d   = '0;
                lo_d   = b_i;
                opnd_d = a_i;
            end else begin
                hi_d   = '0;
                lo_d   = a_i;
                opnd_d = b_i;
            end
        end else if (step_i) begin
            if (op_q == OP_MUL) begin
                hi_d = sum[W:1];
                lo_d = {sum[0], lo_q[W-1:1]};
            end else begin
                lo_d = {lo_q[W-2:0], ge};
                hi_d = ge ? diff : rem_s[W-1:0];
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            op_q   <= OP_MUL;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            op_q   <= op_d;
        end
    end

    assign op_o   = op_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign hi_d_o = hi_d;
    assign lo_d_o = lo_d;

endmodule

// File: rtl/alu_md_unit.sv
// Sequential 16-bit unsigned multiply/divide unit feeding the FLAGS register.
//
// state   | meaning
// IDLE    | waiting for start; result words hold the last result
// RUN     | iterating one bit per cycle, counter counts down from W
// DONE    | one-cycle completion: done/flags_en high, flags_out valid
module alu_md_unit
    import alu_md_pkg::*;
(
    input  logic     clk,
    input  logic     rst_b,
    alu_md_if.slave  bus
);

    state_e       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [3:0]   flags_q, flags_d;
    logic         load, step, dz_start, dp_op;
    logic [W-1:0] hi, lo, hi_nxt, lo_nxt;

    // Next-state, counter and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        step     = 1'b0;
        dz_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load = 1'b1;
                    if (bus.op == OP_DIV && bus.b == '0) begin
                        dz_start = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d   = 5'(W);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Flags are computed from the result being written on the edge into DONE.
    always_comb begin
        flags_d = 4'b0000;
        if (state_d == ST_DONE)
            flags_d = calc_flags(dz_start ? OP_DIV : dp_op, dz_start, hi_nxt, lo_nxt);
    end

    // State, counter and flag registers.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

    md_iter_datapath u_dp (
        .clk    (clk),
        .rst_b  (rst_b),
        .load_i (load),
        .step_i (step),
        .op_i   (bus.op),
        .dz_i   (dz_start),
        .a_i    (bus.a),
        .b_i    (bus.b),
        .op_o   (dp_op),
        .hi_o   (hi),
        .lo_o   (lo),
        .hi_d_o (hi_nxt),
        .lo_d_o (lo_nxt)
    );

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.flags_en  = (state_q == ST_DONE);
    assign bus.flags_out = flags_q;
    assign bus.res_lo    = lo;
    assign bus.res_hi    = hi;

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed bench for alu_md_unit: latency, results, flags, ignore-while-busy
// and reset abort, with hand-computed expected values.
module tb_alu_md_unit;
    import alu_md_pkg::*;

    logic clk;
    logic rst_b;
    int   total;
    int   bad;

    alu_md_if bus ();

    alu_md_unit dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues a request at the current negedge and checks the completion.
    task automatic run_op(input string tag, input logic op, input logic [15:0] a,
                          input logic [15:0] b, input int exp_lat,
                          input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                          input logic [3:0] exp_flags);
        int n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        chk({tag, ".busy"}, 32'(bus.busy), (exp_lat == 1) ? 32'd0 : 32'd1);
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
            if (exp_lat == 1) chk({tag, ".busy_dz"}, 32'(bus.busy), 32'd0);
        end
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ".res_lo"}, 32'(bus.res_lo), 32'(exp_lo));
        chk({tag, ".res_hi"}, 32'(bus.res_hi), 32'(exp_hi));
        chk({tag, ".flags"}, 32'(bus.flags_out), 32'(exp_flags));
        chk({tag, ".flags_en"}, 32'(bus.flags_en), 32'd1);
        @(negedge clk);
        chk({tag, ".done_1cyc"}, 32'(bus.done), 32'd0);
        chk({tag, ".en_1cyc"}, 32'(bus.flags_en), 32'd0);
        chk({tag, ".flags_clr"}, 32'(bus.flags_out), 32'd0);
        chk({tag, ".hold_lo"}, 32'(bus.res_lo), 32'(exp_lo));
    endtask

    initial begin
        int n;
        int pulses;
        total     = 0;
        bad       = 0;
        rst_b     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.flags_en", 32'(bus.flags_en), 32'd0);
        chk("rst.flags", 32'(bus.flags_out), 32'd0);
        chk("rst.res_lo", 32'(bus.res_lo), 32'd0);
        chk("rst.res_hi", 32'(bus.res_hi), 32'd0);
        rst_b = 1'b0;
        @(negedge clk);

        // Back-to-back requests: each starts in the IDLE cycle after DONE.
        run_op("mul3x5",  OP_MUL, 16'd3,    16'd5,    17, 16'h000F, 16'h0000, 4'b0000);
        run_op("mulFxF",  OP_MUL, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 4'b0110);
        run_op("div100_7", OP_DIV, 16'd100, 16'd7,    17, 16'h000E, 16'h0002, 4'b0000);
        run_op("div_by0", OP_DIV, 16'h1234, 16'h0000, 1,  16'hFFFF, 16'h1234, 4'b1010);
        run_op("mul0",    OP_MUL, 16'h0000, 16'h1234, 17, 16'h0000, 16'h0000, 4'b0001);
        run_op("mul8000x2", OP_MUL, 16'h8000, 16'd2,  17, 16'h0000, 16'h0001, 4'b0100);
        run_op("div3_7",  OP_DIV, 16'd3,    16'd7,    17, 16'h0000, 16'h0003, 4'b0001);
        run_op("divF_1",  OP_DIV, 16'hFFFF, 16'd1,    17, 16'hFFFF, 16'h0000, 4'b0010);

        // Start while busy is ignored.
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 16'd2;
        bus.b     = 16'd2;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        repeat (3) begin @(negedge clk); n++; end
        bus.start = 1'b1;
        bus.a     = 16'd9;
        bus.b     = 16'd9;
        @(negedge clk);
        n++;
        bus.start = 1'b0;
        while (!bus.done && n < 40) begin @(negedge clk); n++; end
        chk("ign.latency", 32'(n), 32'd17);
        chk("ign.res_lo", 32'(bus.res_lo), 32'd4);
        chk("ign.res_hi", 32'(bus.res_hi), 32'd0);
        chk("ign.flags", 32'(bus.flags_out), 32'd0);
        @(negedge clk);
        chk("ign.no_requeue", 32'(bus.busy), 32'd0);

        // Reset mid-RUN aborts with no done pulse.
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 16'd50;
        bus.b     = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.done", 32'(bus.done), 32'd0);
        chk("abort.flags", 32'(bus.flags_out), 32'd0);
        chk("abort.res_lo", 32'(bus.res_lo), 32'd0);
        chk("abort.res_hi", 32'(bus.res_hi), 32'd0);
        pulses = 0;
        repeat (3) begin @(negedge clk); if (bus.flags_en) pulses++; end
        rst_b = 1'b0;
        repeat (20) begin @(negedge clk); if (bus.flags_en) pulses++; end
        chk("abort.no_flags_write", 32'(pulses), 32'd0);

        run_op("div50_5", OP_DIV, 16'd50, 16'd5, 17, 16'h000A, 16'h0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
